// File: rtl/run_step_controller.sv
// Processor run/step controller: gates the core clock-enable for limit, single-step and free runs.
// Every output is registered; stop priority is halt_req > cpu_halted > limit.
module run_step_controller #(
   parameter int CNT_W         = 16,
   parameter int DEFAULT_LIMIT = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [CNT_W-1:0] limit,
   input  logic             step,
   input  logic             halt_req,
   input  logic             cpu_halted,
   output logic             run_en,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic             busy,
   output logic             done,
   output logic [1:0]       stop_cause
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'b00,
      S_RUN       = 2'b01,
      S_STEP_WAIT = 2'b10,
      S_DONE      = 2'b11
   } state_t;

   localparam logic [1:0]       CAUSE_NONE  = 2'b00;
   localparam logic [1:0]       CAUSE_LIMIT = 2'b01;
   localparam logic [1:0]       CAUSE_CPU   = 2'b10;
   localparam logic [1:0]       CAUSE_ABORT = 2'b11;
   localparam logic [CNT_W-1:0] ONE         = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic             run_en_q, run_en_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [1:0]       cause_q, cause_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] limit_q, limit_d;
   logic             free_q, free_d;
   logic [CNT_W-1:0] limit_eff;
   logic             last_cycle;

   assign limit_eff  = (limit == '0) ? CNT_W'(DEFAULT_LIMIT) : limit;
   // Current enabled cycle is the L-th one of a limit run.
   assign last_cycle = (cnt_q == (limit_q - ONE));

   always_comb begin
      state_d  = state_q;
      run_en_d = 1'b0;
      cause_d  = cause_q;
      limit_d  = limit_q;
      free_d   = free_q;
      cnt_d    = cnt_q;
      if (run_en_q && (cnt_q != '1)) begin
         cnt_d = cnt_q + ONE;
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               free_d  = (mode == 2'b10);
               limit_d = limit_eff;
               cnt_d   = '0;
               cause_d = CAUSE_NONE;
               if (mode == 2'b01) begin
                  state_d = S_STEP_WAIT;
               end else begin
                  state_d  = S_RUN;
                  run_en_d = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (halt_req) begin
               state_d = S_DONE;
               cause_d = CAUSE_ABORT;
            end else if (run_en_q && cpu_halted) begin
               state_d = S_DONE;
               cause_d = CAUSE_CPU;
            end else if (!free_q && last_cycle) begin
               state_d = S_DONE;
               cause_d = CAUSE_LIMIT;
            end else begin
               run_en_d = 1'b1;
            end
         end
         S_STEP_WAIT: begin
            if (halt_req) begin
               state_d = S_DONE;
               cause_d = CAUSE_ABORT;
            end else if (run_en_q && cpu_halted) begin
               state_d = S_DONE;
               cause_d = CAUSE_CPU;
            end else begin
               // A step arriving during an enabled cycle is dropped, not queued.
               run_en_d = step && !run_en_q;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_RUN) || (state_d == S_STEP_WAIT);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         run_en_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         cause_q  <= CAUSE_NONE;
         cnt_q    <= '0;
         limit_q  <= '0;
         free_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         run_en_q <= run_en_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         cause_q  <= cause_d;
         cnt_q    <= cnt_d;
         limit_q  <= limit_d;
         free_q   <= free_d;
      end
   end

   assign run_en     = run_en_q;
   assign cycle_cnt  = cnt_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign stop_cause = cause_q;

endmodule

// File: tb/tb_run_step_controller.sv
// Bench for run_step_controller: directed requirement scenarios plus randomized runs
// scored against an arithmetic reference of run lengths, step pulses and stop causes.
module tb_run_step_controller;

   localparam int CW   = 6;
   localparam int MAXC = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [1:0]    mode = 2'b00;
   logic [CW-1:0] limit = '0;
   logic          step = 1'b0;
   logic          halt_req = 1'b0;
   logic          cpu_halted = 1'b0;
   logic          run_en;
   logic [CW-1:0] cycle_cnt;
   logic          busy;
   logic          done;
   logic [1:0]    stop_cause;

   int errors = 0;
   int checks = 0;

   run_step_controller #(.CNT_W(CW), .DEFAULT_LIMIT(7)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .limit(limit),
      .step(step), .halt_req(halt_req), .cpu_halted(cpu_halted),
      .run_en(run_en), .cycle_cnt(cycle_cnt), .busy(busy), .done(done),
      .stop_cause(stop_cause)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [CW+4:0] obs();
      return {run_en, busy, done, stop_cause, cycle_cnt};
   endfunction

   function automatic logic [CW+4:0] pk(input logic r, input logic b, input logic d,
                                         input logic [1:0] c, input int n);
      int sat;
      sat = (n > MAXC) ? MAXC : n;
      return {r, b, d, c, CW'(sat)};
   endfunction

   task automatic do_start(input logic [1:0] m, input int lim);
      start = 1'b1;
      mode  = m;
      limit = CW'(lim);
      cyc();
      start = 1'b0;
      mode  = 2'($urandom);
      limit = CW'($urandom);
   endtask

   task automatic test_reset();
      logic [CW+4:0] e;
      rst = 1'b1; start = 1'b1; step = 1'b1; halt_req = 1'b1; cpu_halted = 1'b1;
      cyc(); cyc();
      e = pk(0, 0, 0, 2'b00, 0);
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL reset_state: got %h expected %h", obs(), e); end
      rst = 1'b0; start = 1'b0; cpu_halted = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step = 1'($urandom); halt_req = 1'($urandom);
         cyc();
         checks++;
         if (obs() !== e) begin errors++; $display("FAIL idle_no_action: got %h expected %h", obs(), e); end
      end
      step = 1'b0; halt_req = 1'b0;
   endtask

   task automatic test_limit(input int lim_in, input logic [1:0] m, input bit poke);
      int L;
      logic [CW+4:0] e;
      L = (lim_in == 0) ? 7 : lim_in;
      do_start(m, lim_in);
      for (int i = 0; i < L; i++) begin
         e = pk(1, 1, 0, 2'b00, i);
         checks++;
         if (obs() !== e) begin errors++; $display("FAIL limit_run cyc %0d: got %h expected %h", i, obs(), e); end
         step = 1'($urandom);
         if (poke && i == 0) begin start = 1'b1; mode = 2'b01; limit = CW'(1); end
         cyc();
         start = 1'b0;
      end
      step = 1'b0;
      for (int h = 0; h < 3; h++) begin
         e = pk(0, 0, 1, 2'b01, L);
         checks++;
         if (obs() !== e) begin errors++; $display("FAIL limit_done L=%0d: got %h expected %h", L, obs(), e); end
         step = 1'($urandom); halt_req = 1'($urandom);
         cyc();
      end
      step = 1'b0; halt_req = 1'b0;
   endtask

   task automatic test_limit_priority(input bit hr);
      logic [CW+4:0] e;
      do_start(2'b00, 4);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) begin cpu_halted = 1'b1; halt_req = hr; end
         cyc();
      end
      cpu_halted = 1'b0; halt_req = 1'b0;
      e = pk(0, 0, 1, hr ? 2'b11 : 2'b10, 4);
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL limit_priority hr=%0d: got %h expected %h", hr, obs(), e); end
   endtask

   task automatic test_free(input int N, input bit hr, input bit ch);
      logic [CW+4:0] e;
      do_start(2'b10, int'($urandom_range(1, MAXC)));
      for (int i = 1; i <= N; i++) begin
         e = pk(1, 1, 0, 2'b00, i - 1);
         checks++;
         if (obs() !== e) begin errors++; $display("FAIL free_run cyc %0d: got %h expected %h", i, obs(), e); end
         if (i == 2) begin start = 1'b1; mode = 2'b00; limit = CW'(1); end
         if (i == N) begin halt_req = hr; cpu_halted = ch; end
         cyc();
         start = 1'b0; halt_req = 1'b0; cpu_halted = 1'b0;
      end
      for (int h = 0; h < 2; h++) begin
         e = pk(0, 0, 1, hr ? 2'b11 : 2'b10, N);
         checks++;
         if (obs() !== e) begin errors++; $display("FAIL free_stop N=%0d: got %h expected %h", N, obs(), e); end
         cyc();
      end
   endtask

   task automatic test_step_directed();
      int s_pat[11];
      int run_cur, cnt, pulses;
      logic [CW+4:0] e;
      s_pat = '{1, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0};
      run_cur = 0; cnt = 0; pulses = 0;
      do_start(2'b01, 0);
      for (int c = 0; c < 11; c++) begin
         e = pk(run_cur[0], 1, 0, 2'b00, cnt);
         checks++;
         if (obs() !== e) begin errors++; $display("FAIL step_dir cyc %0d: got %h expected %h", c, obs(), e); end
         pulses += int'(run_en);
         step = s_pat[c][0];
         cyc();
         cnt += run_cur;
         run_cur = (run_cur == 0 && s_pat[c] != 0) ? 1 : 0;
      end
      step = 1'b0;
      checks++;
      if (pulses !== 3) begin errors++; $display("FAIL step_pulse_count: got %0d expected 3", pulses); end
      e = pk(0, 1, 0, 2'b00, 3);
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL step_after: got %h expected %h", obs(), e); end
      step = 1'b1;
      cyc();
      step = 1'b0; cpu_halted = 1'b1;
      cyc();
      cpu_halted = 1'b0;
      e = pk(0, 0, 1, 2'b10, 4);
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL step_cpu_halt: got %h expected %h", obs(), e); end
   endtask

   task automatic test_step_random();
      int run_cur, cnt;
      bit s;
      logic [CW+4:0] e;
      run_cur = 0; cnt = 0;
      do_start(2'b01, 0);
      for (int c = 0; c < 40; c++) begin
         e = pk(run_cur[0], 1, 0, 2'b00, cnt);
         checks++;
         if (obs() !== e) begin errors++; $display("FAIL step_rand cyc %0d: got %h expected %h", c, obs(), e); end
         s = ($urandom_range(0, 9) < 4);
         step = s;
         cpu_halted = (run_cur == 0) ? 1'($urandom) : 1'b0;
         cyc();
         cnt += run_cur;
         run_cur = (run_cur == 0 && s) ? 1 : 0;
      end
      step = 1'b0; cpu_halted = 1'b0;
      if (run_cur != 0) begin
         cyc();
         cnt += 1;
      end
      halt_req = 1'b1; step = 1'b1;
      cyc();
      halt_req = 1'b0; step = 1'b0;
      e = pk(0, 0, 1, 2'b11, cnt);
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL step_abort: got %h expected %h", obs(), e); end
   endtask

   task automatic test_reset_midrun();
      logic [CW+4:0] e;
      do_start(2'b00, 20);
      for (int i = 0; i < 10; i++) begin
         if (i == 9) begin rst = 1'b1; start = 1'b1; mode = 2'b10; end
         cyc();
      end
      e = pk(0, 0, 0, 2'b00, 0);
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL reset_midrun: got %h expected %h", obs(), e); end
      rst = 1'b0; start = 1'b0;
      cyc();
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL reset_idle_hold: got %h expected %h", obs(), e); end
      test_limit(20, 2'b00, 0);
   endtask

   initial begin
      int kind;
      #1;
      test_reset();
      test_limit(0, 2'b00, 0);
      test_limit(1, 2'b00, 0);
      test_step_directed();
      test_free(5, 0, 1);
      test_free(3, 1, 1);
      test_reset_midrun();
      test_limit_priority(0);
      test_limit_priority(1);
      test_free(70, 1, 0);
      for (int r = 0; r < 5; r++) begin
         test_limit(int'($urandom_range(0, 12)), ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00,
                    1'($urandom));
      end
      for (int r = 0; r < 4; r++) begin
         kind = int'($urandom_range(1, 3));
         test_free(int'($urandom_range(1, 10)), kind[0], kind[1]);
      end
      test_step_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
